// File: rtl/cla_wide_add_seq_pkg.sv
// Shared constants for the wide add/subtract sequencer: slice width, FSM encodings,
// and the index-width helper.
package cla_wide_add_seq_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Slice-index width; at least one bit so that WORDS=1 still has a counter
    function automatic int unsigned idx_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/cla_wide_add_seq_if.sv
// Request/response bundle between a bignum client (master) and the wide-add sequencer (slave).
interface cla_wide_add_seq_if
    import cla_wide_add_seq_pkg::*;
#(
    parameter int unsigned WORDS = 4
);
    localparam int unsigned OP_W = WORDS * WORD_W;

    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] in_a;
    logic [OP_W-1:0] in_b;
    logic            in_cin;
    logic            in_sub;
    logic            out_valid;
    logic            out_ready;
    logic [OP_W-1:0] out_sum;
    logic            out_cout;
    logic            busy;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, busy
    );

endinterface

// File: rtl/cla_wide_add_seq_cla.sv
// 32-bit recursive-doubling (Kogge-Stone) carry-lookahead adder; purely combinational.
module cla_wide_add_seq_cla
    import cla_wide_add_seq_pkg::*;
(
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    input  logic              iniC,
    output logic [WORD_W-1:0] Sum,
    output logic              Carry
);
    localparam int unsigned LEVELS = $clog2(WORD_W);

    logic [WORD_W-1:0] g;
    logic [WORD_W-1:0] p;
    logic [WORD_W-1:0] gn;
    logic [WORD_W-1:0] pn;
    logic [WORD_W-1:0] c;

    // Prefix tree: after level s, g/p cover spans of 2^(s+1) bits ending at each position
    always_comb begin
        g = A & B;
        p = A ^ B;
        gn = g;
        pn = p;
        for (int s = 0; s < LEVELS; s++) begin
            gn = g;
            pn = p;
            for (int i = (1 << s); i < WORD_W; i++) begin
                gn[i] = g[i] | (p[i] & g[i - (1 << s)]);
                pn[i] = p[i] & p[i - (1 << s)];
            end
            g = gn;
            p = pn;
        end
        c     = {g[WORD_W-2:0] | (p[WORD_W-2:0] & {(WORD_W-1){iniC}}), iniC};
        Sum   = A ^ B ^ c;
        Carry = g[WORD_W-1] | (p[WORD_W-1] & iniC);
    end

endmodule

// File: rtl/cla_wide_add_seq.sv
// WORDS*32-bit add/subtract: streams one 32-bit slice per cycle, LSW first, through a single
// shared CLA with the inter-slice carry held in a register.
module cla_wide_add_seq
    import cla_wide_add_seq_pkg::*;
#(
    parameter int unsigned WORDS = 4
)(
    input  logic                clk,
    input  logic                rst,
    cla_wide_add_seq_if.slave   bus
);
    localparam int unsigned OP_W  = WORDS * WORD_W;
    localparam int unsigned IDX_W = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    logic [1:0]        state;
    logic [1:0]        state_d;
    logic [IDX_W-1:0]  idx;
    logic              carry;
    logic [OP_W-1:0]   a_q;
    logic [OP_W-1:0]   b_q;
    logic [OP_W-1:0]   sum_q;
    logic              cout_q;
    logic              out_valid_q;
    logic              in_ready_q;
    logic              busy_q;

    logic [WORD_W-1:0] cla_a;
    logic [WORD_W-1:0] cla_b;
    logic [WORD_W-1:0] cla_sum;
    logic              cla_carry;

    // Next-state logic; the illegal encoding falls back to IDLE
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (bus.in_valid) state_d = ST_RUN;
            ST_RUN:  if (idx == LAST) state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Slice mux onto the shared adder
    always_comb begin
        cla_a = '0;
        cla_b = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx == IDX_W'(w)) begin
                cla_a = a_q[w*WORD_W +: WORD_W];
                cla_b = b_q[w*WORD_W +: WORD_W];
            end
        end
    end

    cla_wide_add_seq_cla u_cla (
        .A     (cla_a),
        .B     (cla_b),
        .Sum   (cla_sum),
        .iniC  (carry),
        .Carry (cla_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            idx         <= '0;
            carry       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else begin
            state       <= state_d;
            in_ready_q  <= (state_d == ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            case (state)
                ST_IDLE: begin
                    // Subtract is A + ~B + 1, so invert B once at accept and seed carry with 1
                    if (bus.in_valid) begin
                        a_q   <= bus.in_a;
                        b_q   <= bus.in_sub ? ~bus.in_b : bus.in_b;
                        carry <= bus.in_sub | bus.in_cin;
                        idx   <= '0;
                    end
                end
                ST_RUN: begin
                    for (int w = 0; w < WORDS; w++) begin
                        if (idx == IDX_W'(w)) sum_q[w*WORD_W +: WORD_W] <= cla_sum;
                    end
                    carry <= cla_carry;
                    idx   <= idx + IDX_W'(1);
                    if (idx == LAST) cout_q <= cla_carry;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;

endmodule

// File: tb/tb_cla_wide_add_seq.sv
// Directed bench for cla_wide_add_seq: WORDS=4 and WORDS=1 instances, hand-computed vectors.
module tb_cla_wide_add_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cla_wide_add_seq_if #(.WORDS(4)) if4 ();
    cla_wide_add_seq_if #(.WORDS(1)) if1 ();

    cla_wide_add_seq #(.WORDS(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    cla_wide_add_seq #(.WORDS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One WORDS=4 transaction; lat counts edges with the accepting edge as edge 1
    task automatic op4(input logic [127:0] a, input logic [127:0] b, input logic cin,
                       input logic sub, output logic [127:0] sum, output logic cout,
                       output int lat);
        int guard = 0;
        while (!if4.in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        check("op4_in_ready", 128'(if4.in_ready), 128'(1));
        if4.in_a = a; if4.in_b = b; if4.in_cin = cin; if4.in_sub = sub; if4.in_valid = 1'b1;
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
        lat = 1;
        while (!if4.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check("op4_out_valid", 128'(if4.out_valid), 128'(1));
        sum  = if4.out_sum;
        cout = if4.out_cout;
        if4.out_ready = 1'b1;
        @(posedge clk); #1;
        if4.out_ready = 1'b0;
    endtask

    logic [127:0] s;
    logic         co;
    int           lat;

    initial begin
        if4.in_valid = 1'b0; if4.out_ready = 1'b0; if4.in_a = '0; if4.in_b = '0;
        if4.in_cin = 1'b0; if4.in_sub = 1'b0;
        if1.in_valid = 1'b0; if1.out_ready = 1'b0; if1.in_a = '0; if1.in_b = '0;
        if1.in_cin = 1'b0; if1.in_sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(if4.in_ready), 128'(1));
        check("rst_out_valid", 128'(if4.out_valid), 128'(0));
        check("rst_busy", 128'(if4.busy), 128'(0));
        check("rst_out_sum", if4.out_sum, 128'(0));
        check("rst_out_cout", 128'(if4.out_cout), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        op4(128'd10000, 128'd20000, 1'b1, 1'b0, s, co, lat);
        check("add_sum", s, 128'd30001);
        check("add_cout", 128'(co), 128'(0));
        check("add_latency", 128'(lat), 128'(5));
        check("post_in_ready", 128'(if4.in_ready), 128'(1));

        op4({128{1'b1}}, 128'd1, 1'b0, 1'b0, s, co, lat);
        check("wrap_sum", s, 128'd0);
        check("wrap_cout", 128'(co), 128'(1));

        op4(128'd45000, 128'd4, 1'b0, 1'b1, s, co, lat);
        check("sub_sum", s, 128'd44996);
        check("sub_cout", 128'(co), 128'(1));

        op4(128'd1, 128'd999, 1'b0, 1'b1, s, co, lat);
        check("sub_neg_sum", s, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFC1A);
        check("sub_neg_cout", 128'(co), 128'(0));

        op4(128'h00000000_00000000_00000000_FFFFFFFF, 128'd1, 1'b0, 1'b0, s, co, lat);
        check("slice_sum", s, 128'h00000000_00000000_00000001_00000000);
        check("slice_cout", 128'(co), 128'(0));

        op4(128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, 1'b0, s, co, lat);
        check("ripple3_sum", s, 128'h00000001_00000000_00000000_00000000);

        // in_cin must be ignored on subtract
        op4(128'd10, 128'd3, 1'b1, 1'b1, s, co, lat);
        check("sub_cin_sum", s, 128'd7);
        op4(128'd5, 128'd5, 1'b0, 1'b1, s, co, lat);
        check("sub_eq_sum", s, 128'd0);
        check("sub_eq_cout", 128'(co), 128'(1));

        // Backpressure in DONE with in_valid asserted
        if4.in_a = 128'd123; if4.in_b = 128'd77; if4.in_cin = 1'b0; if4.in_sub = 1'b0;
        if4.in_valid = 1'b1;
        @(posedge clk); #1;
        if4.in_a = 128'd999999; if4.in_b = 128'd1;
        lat = 1;
        while (!if4.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check("bp_out_valid", 128'(if4.out_valid), 128'(1));
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_valid", 128'(if4.out_valid), 128'(1));
            check("bp_hold_sum", if4.out_sum, 128'd200);
            check("bp_hold_ready", 128'(if4.in_ready), 128'(0));
            @(posedge clk); #1;
        end
        if4.in_valid = 1'b0;
        if4.out_ready = 1'b1;
        @(posedge clk); #1;
        if4.out_ready = 1'b0;
        check("bp_rel_valid", 128'(if4.out_valid), 128'(0));
        check("bp_rel_ready", 128'(if4.in_ready), 128'(1));
        check("bp_rel_busy", 128'(if4.busy), 128'(0));

        // Reset while idx=2 in RUN
        if4.in_a = 128'h00000005_00000005_00000005_00000005;
        if4.in_b = 128'h00000003_00000003_00000003_00000003;
        if4.in_sub = 1'b0; if4.in_valid = 1'b1;
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("mid_busy", 128'(if4.busy), 128'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_in_ready", 128'(if4.in_ready), 128'(1));
        check("mid_rst_out_valid", 128'(if4.out_valid), 128'(0));
        check("mid_rst_out_sum", if4.out_sum, 128'd0);
        check("mid_rst_busy", 128'(if4.busy), 128'(0));
        op4(128'd1, 128'd1, 1'b0, 1'b0, s, co, lat);
        check("after_rst_sum", s, 128'd2);

        // WORDS=1 instance
        if1.in_a = 32'd10000; if1.in_b = 32'd20000; if1.in_cin = 1'b1; if1.in_sub = 1'b0;
        if1.in_valid = 1'b1;
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
        lat = 1;
        while (!if1.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check("w1_out_valid", 128'(if1.out_valid), 128'(1));
        check("w1_sum", 128'(if1.out_sum), 128'd30001);
        check("w1_cout", 128'(if1.out_cout), 128'(0));
        check("w1_latency", 128'(lat), 128'(2));
        if1.out_ready = 1'b1;
        @(posedge clk); #1;
        if1.out_ready = 1'b0;
        check("w1_rel_ready", 128'(if1.in_ready), 128'(1));

        if1.in_a = 32'hFFFF_FFFF; if1.in_b = 32'd1; if1.in_cin = 1'b0;
        if1.in_valid = 1'b1;
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
        lat = 1;
        while (!if1.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check("w1_wrap_valid", 128'(if1.out_valid), 128'(1));
        check("w1_wrap_sum", 128'(if1.out_sum), 128'd0);
        check("w1_wrap_cout", 128'(if1.out_cout), 128'(1));
        if1.out_ready = 1'b1;
        @(posedge clk); #1;
        if1.out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
